fb_mem_arbiter: RTL

- Responder end of the engine-to-arbiter request interface: data/addr/wben/op with rts/rtr.
- Accepts framebuffer access requests from two client engines (client 0 = fill_rect engine, client 1 = second drawing/read engine).
- Arbitrates between them and drives a single-port synchronous framebuffer RAM.
- Returns read data to whichever client issued the read.

---
 rtl/fb_mem_arbiter_if.sv | 56 +++++
 rtl/fb_mem_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fb_mem_arbiter_if.sv
// Request/response bundle shared by the two drawing engines, the framebuffer
// arbiter and the single-port framebuffer RAM.
interface fb_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    localparam int WBEN_W = DATA_W / 8;

    // client 0 (fill_rect engine)
    logic [DATA_W-1:0] c0_in_data;
    logic [ADDR_W-1:0] c0_in_addr;
    logic [WBEN_W-1:0] c0_in_wben;
    logic              c0_in_op;
    logic              c0_in_rts;
    logic              c0_out_rtr;
    logic [DATA_W-1:0] c0_out_rdata;
    logic              c0_out_rvalid;

    // client 1 (second drawing/read engine)
    logic [DATA_W-1:0] c1_in_data;
    logic [ADDR_W-1:0] c1_in_addr;
    logic [WBEN_W-1:0] c1_in_wben;
    logic              c1_in_op;
    logic              c1_in_rts;
    logic              c1_out_rtr;
    logic [DATA_W-1:0] c1_out_rdata;
    logic              c1_out_rvalid;

    // framebuffer RAM
    logic [ADDR_W-1:0] mem_out_addr;
    logic [DATA_W-1:0] mem_out_wdata;
    logic [WBEN_W-1:0] mem_out_wben;
    logic              mem_out_en;
    logic              mem_out_we;
    logic [DATA_W-1:0] mem_in_rdata;

    // arbiter side
    modport slave (
        input  c0_in_data, c0_in_addr, c0_in_wben, c0_in_op, c0_in_rts,
        output c0_out_rtr, c0_out_rdata, c0_out_rvalid,
        input  c1_in_data, c1_in_addr, c1_in_wben, c1_in_op, c1_in_rts,
        output c1_out_rtr, c1_out_rdata, c1_out_rvalid,
        output mem_out_addr, mem_out_wdata, mem_out_wben, mem_out_en, mem_out_we,
        input  mem_in_rdata
    );

    // client/RAM side
    modport master (
        output c0_in_data, c0_in_addr, c0_in_wben, c0_in_op, c0_in_rts,
        input  c0_out_rtr, c0_out_rdata, c0_out_rvalid,
        output c1_in_data, c1_in_addr, c1_in_wben, c1_in_op, c1_in_rts,
        input  c1_out_rtr, c1_out_rdata, c1_out_rvalid,
        input  mem_out_addr, mem_out_wdata, mem_out_wben, mem_out_en, mem_out_we,
        output mem_in_rdata
    );
endinterface

// File: rtl/fb_mem_arbiter.sv
// Two-client framebuffer arbiter: bounded-burst arbitration between the
// engines, one registered RAM request stage, and a tagged read-return pipe.
module fb_mem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4,
    parameter int RD_LAT    = 1
) (
    input  logic            clk,
    input  logic            rst_,
    fb_mem_arbiter_if.slave bus
);
    localparam int WBEN_W = DATA_W / 8;

    typedef enum logic { OWN_C0 = 1'b0, OWN_C1 = 1'b1 } owner_t;

    owner_t            owner, owner_nxt;
    logic [3:0]        burst_cnt, burst_nxt;
    logic              rtr0, rtr1;
    logic              grant, sel;
    logic              sel_op;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [WBEN_W-1:0] sel_wben;

    logic              req_en_p0, req_we_p0, req_id_p0;
    logic [ADDR_W-1:0] req_addr_p0;
    logic [DATA_W-1:0] req_wdata_p0;
    logic [WBEN_W-1:0] req_wben_p0;

    logic [RD_LAT-1:0] tag_vld_p1, tag_id_p1;

    logic [DATA_W-1:0] rdata0_p2, rdata1_p2;
    logic              rvalid0_p2, rvalid1_p2;

    // Grant decision and next arbitration state from the live rts inputs
    always_comb begin
        rtr0      = 1'b0;
        rtr1      = 1'b0;
        owner_nxt = owner;
        burst_nxt = burst_cnt;
        if (rst_) begin
            if (bus.c0_in_rts && bus.c1_in_rts) begin
                if (burst_cnt < 4'(MAX_BURST)) begin
                    rtr0      = (owner == OWN_C0);
                    rtr1      = (owner == OWN_C1);
                    burst_nxt = burst_cnt + 4'd1;
                end else begin
                    // burst limit reached: hand the port to the waiting client
                    rtr0      = (owner == OWN_C1);
                    rtr1      = (owner == OWN_C0);
                    owner_nxt = (owner == OWN_C0) ? OWN_C1 : OWN_C0;
                    burst_nxt = 4'd1;
                end
            end else if (bus.c0_in_rts) begin
                rtr0 = 1'b1;
                if (owner != OWN_C0) begin
                    owner_nxt = OWN_C0;
                    burst_nxt = 4'd1;
                end
            end else if (bus.c1_in_rts) begin
                rtr1 = 1'b1;
                if (owner != OWN_C1) begin
                    owner_nxt = OWN_C1;
                    burst_nxt = 4'd1;
                end
            end
        end
    end

    // Arbitration state register
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            owner     <= OWN_C0;
            burst_cnt <= '0;
        end else begin
            owner     <= owner_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    assign grant    = rtr0 | rtr1;
    assign sel      = rtr1;
    assign sel_op   = sel ? bus.c1_in_op   : bus.c0_in_op;
    assign sel_addr = sel ? bus.c1_in_addr : bus.c0_in_addr;
    assign sel_data = sel ? bus.c1_in_data : bus.c0_in_data;
    assign sel_wben = sel ? bus.c1_in_wben : bus.c0_in_wben;

    // Stage p0: capture the accepted request as the RAM command (writes with no bytes enabled are dropped)
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            req_en_p0    <= 1'b0;
            req_we_p0    <= 1'b0;
            req_id_p0    <= 1'b0;
            req_addr_p0  <= '0;
            req_wdata_p0 <= '0;
            req_wben_p0  <= '0;
        end else if (grant) begin
            if (sel_op) begin
                if (sel_wben != '0) begin
                    req_en_p0    <= 1'b1;
                    req_we_p0    <= 1'b1;
                    req_id_p0    <= sel;
                    req_addr_p0  <= sel_addr;
                    req_wdata_p0 <= sel_data;
                    req_wben_p0  <= sel_wben;
                end else begin
                    req_en_p0 <= 1'b0;
                    req_we_p0 <= 1'b0;
                end
            end else begin
                req_en_p0    <= 1'b1;
                req_we_p0    <= 1'b0;
                req_id_p0    <= sel;
                req_addr_p0  <= sel_addr;
                req_wdata_p0 <= '0;
                req_wben_p0  <= '0;
            end
        end else begin
            req_en_p0 <= 1'b0;
            req_we_p0 <= 1'b0;
        end
    end

    // Stage p1: {valid, client} tag travels RD_LAT cycles alongside each read strobe
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            tag_vld_p1 <= '0;
            tag_id_p1  <= '0;
        end else begin
            tag_vld_p1[0] <= req_en_p0 & ~req_we_p0;
            tag_id_p1[0]  <= req_id_p0;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld_p1[i] <= tag_vld_p1[i-1];
                tag_id_p1[i]  <= tag_id_p1[i-1];
            end
        end
    end

    // Stage p2: register returning RAM data into the tagged client's read port
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            rdata0_p2  <= '0;
            rdata1_p2  <= '0;
            rvalid0_p2 <= 1'b0;
            rvalid1_p2 <= 1'b0;
        end else begin
            rvalid0_p2 <= tag_vld_p1[RD_LAT-1] & ~tag_id_p1[RD_LAT-1];
            rvalid1_p2 <= tag_vld_p1[RD_LAT-1] &  tag_id_p1[RD_LAT-1];
            if (tag_vld_p1[RD_LAT-1] && !tag_id_p1[RD_LAT-1]) begin
                rdata0_p2 <= bus.mem_in_rdata;
            end
            if (tag_vld_p1[RD_LAT-1] && tag_id_p1[RD_LAT-1]) begin
                rdata1_p2 <= bus.mem_in_rdata;
            end
        end
    end

    assign bus.c0_out_rtr    = rtr0;
    assign bus.c1_out_rtr    = rtr1;
    assign bus.c0_out_rdata  = rdata0_p2;
    assign bus.c1_out_rdata  = rdata1_p2;
    assign bus.c0_out_rvalid = rvalid0_p2;
    assign bus.c1_out_rvalid = rvalid1_p2;
    assign bus.mem_out_addr  = req_addr_p0;
    assign bus.mem_out_wdata = req_wdata_p0;
    assign bus.mem_out_wben  = req_wben_p0;
    assign bus.mem_out_en    = req_en_p0;
    assign bus.mem_out_we    = req_we_p0;
endmodule
